// File: rtl/store_byte_merge_pkg.sv
// store_byte_merge_pkg: shared size encoding, FSM states and word geometry for store_byte_merge
package store_byte_merge_pkg;
  localparam int WORD_BYTES = 4;
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    RWAIT = 3'd2,
    WR    = 3'd3,
    WWAIT = 3'd4
  } state_e;
endpackage

// File: rtl/store_byte_merge_byte_lane_merge.sv
// byte_lane_merge: inserts a byte or halfword into a little-endian 32-bit word
module byte_lane_merge
  import store_byte_merge_pkg::*;
(
  input  logic [8*WORD_BYTES-1:0] oldWord,
  input  logic [31:0]             data,
  input  size_e                   size,
  input  logic [1:0]              lane,
  output logic [8*WORD_BYTES-1:0] merged
);
  always_comb begin
    merged = oldWord;
    if (size == SZ_BYTE) merged[{lane, 3'b000} +: 8] = data[7:0];
    else if (size == SZ_HALF) merged[{lane[1], 4'b0000} +: 16] = data[15:0];
    else merged = data;
  end
endmodule

// File: rtl/store_byte_merge.sv
// store_byte_merge: read-modify-write sub-word store engine; define STORE_HALF_EN to enable halfword stores
module store_byte_merge
  import store_byte_merge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
  input  logic              mem_wack
);
`ifdef STORE_HALF_EN
  localparam bit HALF_EN = 1'b1;
`else
  localparam bit HALF_EN = 1'b0;
`endif
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e            state;
  size_e             sizeQ;
  logic              readyQ;
  logic [ADDR_W-1:0] addrQ;
  logic [31:0]       dataQ, wordQ, merged;
  logic [CW-1:0]     cnt;
  logic              bad, timeUp;
  assign bad = req_size == 2'b11 || (req_size == SZ_WORD && req_addr[1:0] != 2'b00) ||
               (req_size == SZ_HALF && (!HALF_EN || req_addr[0]));
  assign timeUp    = cnt == CW'(TIMEOUT - 1);
  assign req_ready = readyQ && state == IDLE;
  assign mem_rd_en = state == RD;
  assign mem_wr_en = state == WR;
  assign mem_addr  = {addrQ[ADDR_W-1:2], 2'b00};
  assign mem_wdata = wordQ;
  byte_lane_merge u_merge (
    .oldWord(mem_rdata),
    .data   (dataQ),
    .size   (sizeQ),
    .lane   (addrQ[1:0]),
    .merged (merged)
  );
  // Every wait state is entered from RD or WR, so the counter is already zero on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sizeQ  <= SZ_BYTE;
      readyQ <= 1'b0;
      addrQ  <= '0;
      dataQ  <= '0;
      wordQ  <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      readyQ <= 1'b1;
      done   <= 1'b0;
      err    <= 1'b0;
      cnt    <= (state == RWAIT || state == WWAIT) ? cnt + 1'b1 : '0;
      case (state)
        IDLE: if (req_valid && req_ready) begin
          addrQ <= req_addr;
          dataQ <= req_wdata;
          sizeQ <= size_e'(req_size);
          wordQ <= req_wdata;
          if (bad) err <= 1'b1;
          else state <= (req_size == SZ_WORD) ? WR : RD;
        end
        RD: state <= RWAIT;
        RWAIT: if (mem_rvalid) begin
          wordQ <= merged;
          state <= WR;
        end else if (timeUp) begin
          err   <= 1'b1;
          state <= IDLE;
        end
        WR: state <= WWAIT;
        WWAIT: if (mem_wack) begin
          done  <= 1'b1;
          state <= IDLE;
        end else if (timeUp) begin
          err   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/store_byte_merge.md
STORE_BYTE_MERGE -- requirements
Module: store_byte_merge

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter ADDR_W, default 32, SHALL set the byte-address width.
REQ-003 Parameter TIMEOUT, default 255, SHALL set the maximum number of cycles spent waiting for a memory response.
REQ-004 Ports SHALL be:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  store request.
- req_ready  out  1  block can accept a request.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- req_size  in  2  00 byte, 01 half, 10 word.
- done  out  1  one-cycle pulse when the store completes.
- err  out  1  one-cycle pulse when the store is aborted.
- mem_addr  out  ADDR_W  word-aligned address, with addr[1:0]=0.
- mem_rd_en  out  1  read strobe.
- mem_rdata  in  32  read data.
- mem_rvalid  in  1  read data valid.
- mem_wr_en  out  1  write strobe.
- mem_wdata  out  32  merged write word.
- mem_wack  in  1  write accepted.

Function
REQ-005 The block SHALL be the store-side inverse of the load extender: it inserts a byte or halfword into a 32-bit little-endian memory word by read-modify-write.
- Byte lane = addr[1:0].
- Half lane = addr[1].
REQ-006 The FSM states SHALL be IDLE, RD, RWAIT, WR and WWAIT.
- IDLE -> RD on req_valid&&req_ready when size is byte or half.
- IDLE -> WR directly when size is word (no read).
REQ-007 req_ready SHALL be 1 only in IDLE; a request SHALL be registered (addr, wdata, size) on the accepting cycle.
REQ-008 RD SHALL assert mem_rd_en for exactly one cycle, then enter RWAIT.
REQ-009 In RWAIT, on mem_rvalid, the block SHALL merge the request data into the returned word and enter WR.
- Byte: replace bits [8*lane+7 : 8*lane] with wdata[7:0].
- Half: replace bits [16*addr[1]+15 : 16*addr[1]] with wdata[15:0].
- All other bits of mem_rdata SHALL be preserved.
REQ-010 WR SHALL assert mem_wr_en with mem_wdata for one cycle, then enter WWAIT; on mem_wack the block SHALL pulse done and return to IDLE.
REQ-011 mem_wr_en and mem_rd_en SHALL never be asserted in the same cycle.
REQ-012 mem_addr SHALL be {req_addr[ADDR_W-1:2],2'b00} from RD through WWAIT.
REQ-013 Misaligned requests (word with addr[1:0]!=0, or half with addr[0]=1) SHALL be accepted, issue no memory access, and pulse err on the next cycle.
REQ-014 If RWAIT or WWAIT lasts TIMEOUT cycles without a response, the block SHALL pulse err and return to IDLE.
- The wait counter SHALL clear on each state entry.
REQ-015 A response strobe arriving outside its wait state SHALL be ignored.
REQ-016 req_size=11 SHALL be treated as misaligned (err).
REQ-017 done and err SHALL never pulse in the same cycle.

Reset
REQ-018 Asserting rst_n low SHALL immediately force IDLE and clear all outputs: req_ready=0 during reset, done=0, err=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, counter=0.
REQ-019 req_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-020 Reset mid-transaction SHALL abandon the transaction with no done/err pulse.

Configuration
REQ-021 With STORE_HALF_EN defined, halfword stores SHALL be supported per REQ-009.
REQ-022 Without STORE_HALF_EN, req_size=01 SHALL be treated as an unsupported size and pulse err without any memory access.

Structure
REQ-023 A shared package SHALL hold:
- the size encoding enum (SZ_BYTE, SZ_HALF, SZ_WORD).
- the FSM state enum.
- the constant WORD_BYTES=4.
REQ-024 The merge datapath SHALL be the sub-module byte_lane_merge (combinational: old word, data, size, lane -> merged word).

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Byte store: addr 0x103, wdata 0xAB, mem_rdata 0x11223344 -> mem_wdata 0xAB223344 at mem_addr 0x100, then done.
- Word store: addr 0x200, wdata 0xDEADBEEF -> no mem_rd_en, mem_wr_en with 0xDEADBEEF, done after mem_wack.
- Half store (STORE_HALF_EN defined): addr 0x102, wdata 0x5566, rdata 0x11223344 -> 0x55663344; without the macro -> err, no memory access.
- Misaligned word at addr 0x201 -> err one cycle after acceptance, mem_rd_en and mem_wr_en stay 0.
- mem_rvalid withheld for TIMEOUT=4 cycles -> err, IDLE, req_ready=1; a late mem_rvalid is ignored.
- rst_n low during WWAIT -> all outputs 0, no done; the next request completes normally.
